// File: rtl/pong_params.sv
// Shared Pong geometry and FSM encoding, used by the engine and by graphics.
package pong_params;

  localparam int CANVAS_TOP    = 50;
  localparam int CANVAS_BOTTOM = 450;
  localparam int CANVAS_LEFT   = 50;
  localparam int CANVAS_RIGHT  = 600;
  localparam int BALL_SIZE     = 10;
  localparam int PADDLE_OFFSET = 20;
  localparam int PADDLE_HEIGHT = 50;
  localparam int PADDLE_WIDTH  = 10;
  localparam int PADDLE_STEP   = 4;
  localparam int BALL_SPEED    = 2;
  localparam int WIN_SCORE     = 9;
  localparam int HOLD_FRAMES   = 60;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SCORED,
    ST_GAME_OVER
  } state_t;

endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: steps up/down on enabled frames, clamped to its travel range.
module paddle_ctrl #(
  parameter int POS_MIN = 51,
  parameter int POS_MAX = 400,
  parameter int STEP    = 4,
  parameter int HOME    = 225
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  input  logic       load,
  input  logic       up,
  input  logic       down,
  output logic [9:0] pos
);

  localparam logic [10:0] MIN11  = 11'(POS_MIN);
  localparam logic [10:0] MAX11  = 11'(POS_MAX);
  localparam logic [10:0] STEP11 = 11'(STEP);

  logic [10:0] pos11;
  assign pos11 = {1'b0, pos};

  // Pressing both buttons cancels out, so only exclusive presses move.
  always_ff @(posedge clk) begin
    if (reset || load)
      pos <= 10'(HOME);
    else if (step_en && up && !down)
      pos <= (pos11 < MIN11 + STEP11) ? 10'(POS_MIN) : 10'(pos11 - STEP11);
    else if (step_en && down && !up)
      pos <= (pos11 + STEP11 > MAX11) ? 10'(POS_MAX) : 10'(pos11 + STEP11);
  end

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: ball motion, collisions, scoring and game FSM, advanced once per frame_tick.
module pong_engine #(
  parameter int CANVAS_TOP    = pong_params::CANVAS_TOP,
  parameter int CANVAS_BOTTOM = pong_params::CANVAS_BOTTOM,
  parameter int CANVAS_LEFT   = pong_params::CANVAS_LEFT,
  parameter int CANVAS_RIGHT  = pong_params::CANVAS_RIGHT,
  parameter int BALL_SIZE     = pong_params::BALL_SIZE,
  parameter int PADDLE_OFFSET = pong_params::PADDLE_OFFSET,
  parameter int PADDLE_HEIGHT = pong_params::PADDLE_HEIGHT,
  parameter int PADDLE_WIDTH  = pong_params::PADDLE_WIDTH,
  parameter int PADDLE_STEP   = pong_params::PADDLE_STEP,
  parameter int BALL_SPEED    = pong_params::BALL_SPEED,
  parameter int WIN_SCORE     = pong_params::WIN_SCORE,
  parameter int HOLD_FRAMES   = pong_params::HOLD_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_lu,
  input  logic       btn_ld,
  input  logic       btn_ru,
  input  logic       btn_rd,
  input  logic       serve,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [9:0] paddle_left_pos,
  output logic [9:0] paddle_right_pos,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over
);
  import pong_params::*;

  localparam int HOLD_W    = $clog2(HOLD_FRAMES);
  localparam int PADDLE_Y0 = (CANVAS_TOP + CANVAS_BOTTOM) / 2 - PADDLE_HEIGHT / 2;

  localparam logic [9:0]  BALL_X0 = 10'((CANVAS_LEFT + CANVAS_RIGHT) / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  BALL_Y0 = 10'((CANVAS_TOP + CANVAS_BOTTOM) / 2 - BALL_SIZE / 2);
  localparam logic [10:0] TOP_MIN = 11'(CANVAS_TOP + 1);
  localparam logic [10:0] BOTTOM  = 11'(CANVAS_BOTTOM);
  localparam logic [10:0] LEFT    = 11'(CANVAS_LEFT);
  localparam logic [10:0] RIGHT   = 11'(CANVAS_RIGHT);
  localparam logic [10:0] SZ      = 11'(BALL_SIZE);
  localparam logic [10:0] SPD     = 11'(BALL_SPEED);
  localparam logic [10:0] PH      = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] L_FACE  = 11'(CANVAS_LEFT + PADDLE_OFFSET + PADDLE_WIDTH);
  localparam logic [10:0] R_FACE  = 11'(CANVAS_RIGHT - PADDLE_OFFSET - PADDLE_WIDTH);
  localparam logic [3:0]  WIN4    = 4'(WIN_SCORE);

  state_t            state, state_n;
  logic [9:0]        ball_x_n, ball_y_n;
  logic              dir_x, dir_x_n;         // 1 = moving right
  logic              dir_y, dir_y_n;         // 1 = moving down
  logic              serve_dir, serve_dir_n; // 1 = serve to the right
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic [3:0]        score_left_n, score_right_n;
  logic              game_over_n;
  logic              paddle_en, paddle_load;

  logic [10:0] x11, y11, pl11, pr11;
  logic        overlap_l, overlap_r;

  assign x11  = {1'b0, ball_pos_x};
  assign y11  = {1'b0, ball_pos_y};
  assign pl11 = {1'b0, paddle_left_pos};
  assign pr11 = {1'b0, paddle_right_pos};

  assign overlap_l = (y11 + SZ > pl11) && (y11 < pl11 + PH);
  assign overlap_r = (y11 + SZ > pr11) && (y11 < pr11 + PH);

  assign paddle_en   = frame_tick && (state != ST_GAME_OVER);
  assign paddle_load = frame_tick && (state == ST_GAME_OVER) && serve;

  paddle_ctrl #(
    .POS_MIN(CANVAS_TOP + 1), .POS_MAX(CANVAS_BOTTOM - PADDLE_HEIGHT),
    .STEP(PADDLE_STEP), .HOME(PADDLE_Y0)
  ) u_paddle_left (
    .clk(clk), .reset(reset), .step_en(paddle_en), .load(paddle_load),
    .up(btn_lu), .down(btn_ld), .pos(paddle_left_pos)
  );

  paddle_ctrl #(
    .POS_MIN(CANVAS_TOP + 1), .POS_MAX(CANVAS_BOTTOM - PADDLE_HEIGHT),
    .STEP(PADDLE_STEP), .HOME(PADDLE_Y0)
  ) u_paddle_right (
    .clk(clk), .reset(reset), .step_en(paddle_en), .load(paddle_load),
    .up(btn_ru), .down(btn_rd), .pos(paddle_right_pos)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ball_pos_x  <= BALL_X0;
      ball_pos_y  <= BALL_Y0;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      serve_dir   <= 1'b1;
      hold_cnt    <= '0;
      score_left  <= '0;
      score_right <= '0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_n;
      ball_pos_x  <= ball_x_n;
      ball_pos_y  <= ball_y_n;
      dir_x       <= dir_x_n;
      dir_y       <= dir_y_n;
      serve_dir   <= serve_dir_n;
      hold_cnt    <= hold_cnt_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
      game_over   <= game_over_n;
    end
  end

  always_comb begin
    // NOTE: every output is defaulted to its held value first so no path infers a latch.
    state_n       = state;
    ball_x_n      = ball_pos_x;
    ball_y_n      = ball_pos_y;
    dir_x_n       = dir_x;
    dir_y_n       = dir_y;
    serve_dir_n   = serve_dir;
    hold_cnt_n    = hold_cnt;
    score_left_n  = score_left;
    score_right_n = score_right;
    game_over_n   = game_over;

    if (frame_tick) begin
      unique case (state)
        ST_IDLE: begin
          ball_x_n = BALL_X0;
          ball_y_n = BALL_Y0;
          if (serve) begin
            state_n = ST_PLAY;
            dir_x_n = serve_dir;
            dir_y_n = 1'b1;
          end
        end

        ST_PLAY: begin
          if (!dir_y) begin
            if (y11 < TOP_MIN + SPD) begin
              ball_y_n = 10'(TOP_MIN);
              dir_y_n  = 1'b1;
            end else ball_y_n = 10'(y11 - SPD);
          end else begin
            if (y11 + SPD + SZ > BOTTOM) begin
              ball_y_n = 10'(BOTTOM - SZ);
              dir_y_n  = 1'b0;
            end else ball_y_n = 10'(y11 + SPD);
          end

          // A paddle hit is checked before the miss so it always wins.
          if (!dir_x && x11 >= L_FACE && x11 < L_FACE + SPD && overlap_l) begin
            ball_x_n = 10'(L_FACE);
            dir_x_n  = 1'b1;
          end else if (dir_x && x11 + SZ <= R_FACE && x11 + SPD + SZ > R_FACE && overlap_r) begin
            ball_x_n = 10'(R_FACE - SZ);
            dir_x_n  = 1'b0;
          end else if ((!dir_x && x11 <= LEFT + SPD) || (dir_x && x11 + SPD + SZ >= RIGHT)) begin
            ball_x_n    = BALL_X0;
            ball_y_n    = BALL_Y0;
            serve_dir_n = dir_x;  // the player who conceded receives the serve
            hold_cnt_n  = '0;
            if (dir_x) begin
              if (score_left < WIN4) score_left_n = score_left + 4'd1;
            end else begin
              if (score_right < WIN4) score_right_n = score_right + 4'd1;
            end
            if (score_left_n == WIN4 || score_right_n == WIN4) begin
              state_n     = ST_GAME_OVER;
              game_over_n = 1'b1;
            end else state_n = ST_SCORED;
          end else begin
            ball_x_n = dir_x ? 10'(x11 + SPD) : 10'(x11 - SPD);
          end
        end

        ST_SCORED: begin
          if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
            hold_cnt_n = '0;
            state_n    = ST_IDLE;
          end else hold_cnt_n = hold_cnt + 1'b1;
        end

        ST_GAME_OVER: begin
          if (serve) begin
            score_left_n  = '0;
            score_right_n = '0;
            ball_x_n      = BALL_X0;
            ball_y_n      = BALL_Y0;
            game_over_n   = 1'b0;
            state_n       = ST_IDLE;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: a velocity-based game model checked every cycle, plus directed literal checks.
module tb_pong_engine;

  logic       clk = 1'b0;
  logic       reset, frame_tick, btn_lu, btn_ld, btn_ru, btn_rd, serve;
  logic [9:0] ball_pos_x, ball_pos_y, paddle_left_pos, paddle_right_pos;
  logic [3:0] score_left, score_right;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural game model: positions as ints, velocities as signed +/-2.
  int m_bx, m_by, m_vx, m_vy, m_pl, m_pr, m_sl, m_sr, m_sdir, m_hold;
  bit m_rally, m_over;

  pong_engine dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_lu(btn_lu), .btn_ld(btn_ld), .btn_ru(btn_ru), .btn_rd(btn_rd),
    .serve(serve),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .paddle_left_pos(paddle_left_pos), .paddle_right_pos(paddle_right_pos),
    .score_left(score_left), .score_right(score_right), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int paddle_move(input int p, input bit u, input bit d);
    if (u && !d) return (p - 4 < 51) ? 51 : p - 4;
    if (d && !u) return (p + 4 > 400) ? 400 : p + 4;
    return p;
  endfunction

  task automatic centre();
    m_bx = 320;
    m_by = 245;
  endtask

  task automatic rally(input int opl, input int opr);
    int nx, ny;
    ny = m_by + m_vy;
    if (ny < 51) begin ny = 51; m_vy = 2; end
    else if (ny + 10 > 450) begin ny = 440; m_vy = -2; end
    nx = m_bx + m_vx;
    if (m_vx < 0 && m_bx >= 80 && nx < 80 && m_by + 10 > opl && m_by < opl + 50) begin
      nx = 80; m_vx = 2;
    end else if (m_vx > 0 && m_bx + 10 <= 570 && nx + 10 > 570 && m_by + 10 > opr && m_by < opr + 50) begin
      nx = 560; m_vx = -2;
    end else if ((m_vx < 0 && nx <= 50) || (m_vx > 0 && nx + 10 >= 600)) begin
      if (m_vx > 0) m_sl = (m_sl < 9) ? m_sl + 1 : 9;
      else          m_sr = (m_sr < 9) ? m_sr + 1 : 9;
      m_sdir  = m_vx;
      m_rally = 1'b0;
      if (m_sl == 9 || m_sr == 9) m_over = 1'b1;
      else                        m_hold = 60;
      nx = 320; ny = 245;
    end
    m_bx = nx;
    m_by = ny;
  endtask

  task automatic model_step(input bit rst, input bit tick, input bit [3:0] btn, input bit srv);
    int opl, opr;
    if (rst) begin
      centre();
      m_pl = 225; m_pr = 225; m_sl = 0; m_sr = 0;
      m_over = 1'b0; m_rally = 1'b0; m_hold = 0;
      m_sdir = 2; m_vx = 2; m_vy = 2;
      return;
    end
    if (!tick) return;
    opl = m_pl;
    opr = m_pr;
    if (!m_over) begin
      m_pl = paddle_move(m_pl, btn[3], btn[2]);
      m_pr = paddle_move(m_pr, btn[1], btn[0]);
    end
    if (m_over) begin
      if (srv) begin
        m_sl = 0; m_sr = 0; m_pl = 225; m_pr = 225;
        centre();
        m_over = 1'b0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (!m_rally) begin
      centre();
      if (srv) begin m_rally = 1'b1; m_vx = m_sdir; m_vy = 2; end
    end else begin
      rally(opl, opr);
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, return at the next falling edge.
  task automatic cyc(input bit rst, input bit tick, input bit [3:0] btn, input bit srv);
    reset = rst; frame_tick = tick; serve = srv;
    {btn_lu, btn_ld, btn_ru, btn_rd} = btn;
    @(posedge clk);
    model_step(rst, tick, btn, srv);
    @(negedge clk);
  endtask

  task automatic ticks(input int n, input bit [3:0] btn, input bit srv);
    repeat (n) cyc(1'b0, 1'b1, btn, srv);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ball_x",       ball_pos_x,       m_bx);
      check("ball_y",       ball_pos_y,       m_by);
      check("paddle_left",  paddle_left_pos,  m_pl);
      check("paddle_right", paddle_right_pos, m_pr);
      check("score_left",   score_left,       m_sl);
      check("score_right",  score_right,      m_sr);
      check("game_over",    game_over,        int'(m_over));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] btn;
    bit       srv, tk, rs;
    int       mode;

    cyc(1'b1, 1'b0, 4'b0000, 1'b0);
    chk_en = 1'b1;
    ticks(3, 4'b0000, 1'b0);
    check("idle_ball_x", ball_pos_x, 320);
    check("idle_ball_y", ball_pos_y, 245);
    check("idle_paddle_l", paddle_left_pos, 225);
    check("idle_paddle_r", paddle_right_pos, 225);

    // Left paddle climbs 4 per tick to the top floor, stalls with no tick or both buttons.
    for (int k = 1; k <= 60; k++) begin
      ticks(1, 4'b1000, 1'b0);
      check("climb", paddle_left_pos, (225 - 4 * k < 51) ? 51 : 225 - 4 * k);
    end
    repeat (3) cyc(1'b0, 1'b0, 4'b1000, 1'b0);
    ticks(4, 4'b1100, 1'b0);
    check("both_held", paddle_left_pos, 51);
    check("climb_other", paddle_right_pos, 225);

    // Undisturbed serve: bounce at 440 on tick 98, miss on tick 135.
    cyc(1'b1, 1'b0, 4'b0000, 1'b0);
    ticks(1, 4'b0000, 1'b1);
    check("serve_centred", ball_pos_x, 320);
    ticks(97, 4'b0000, 1'b0);
    check("pre_bounce_y", ball_pos_y, 439);
    ticks(1, 4'b0000, 1'b0);
    check("bounce_y", ball_pos_y, 440);
    ticks(1, 4'b0000, 1'b0);
    check("after_bounce_y", ball_pos_y, 438);
    ticks(35, 4'b0000, 1'b0);
    check("pre_miss_x", ball_pos_x, 588);
    check("pre_miss_y", ball_pos_y, 368);
    check("pre_miss_score", score_left, 0);
    ticks(1, 4'b0000, 1'b0);
    check("miss_score", score_left, 1);
    check("miss_centre_x", ball_pos_x, 320);
    check("miss_centre_y", ball_pos_y, 245);
    // Serve held through SCORED is ignored until IDLE is reached.
    ticks(61, 4'b0000, 1'b1);
    check("hold_centre_x", ball_pos_x, 320);
    ticks(1, 4'b0000, 1'b0);
    check("reserve_x", ball_pos_x, 322);
    check("reserve_y", ball_pos_y, 247);

    // Reset on a tick cycle in PLAY wins over the tick.
    ticks(20, 4'b0001, 1'b0);
    cyc(1'b1, 1'b1, 4'b0001, 1'b1);
    check("rst_ball_x", ball_pos_x, 320);
    check("rst_paddle_r", paddle_right_pos, 225);
    check("rst_score_l", score_left, 0);

    // Nine identical right-side misses reach game over.
    ticks(1703, 4'b0000, 1'b1);
    check("pre_win_score", score_left, 8);
    check("pre_win_over", game_over, 0);
    ticks(1, 4'b0000, 1'b1);
    check("win_score", score_left, 9);
    check("win_over", game_over, 1);
    ticks(5, 4'b1001, 1'b0);
    check("frozen_l", paddle_left_pos, 225);
    check("frozen_score", score_left, 9);
    ticks(1, 4'b0000, 1'b1);
    check("restart_score", score_left, 0);
    check("restart_over", game_over, 0);

    // Randomized play: mixed random and ball-tracking paddles.
    mode = 0;
    for (int c = 0; c < 40000; c++) begin
      if (c % 500 == 0) mode = $urandom_range(0, 2);
      btn = 4'($urandom);
      if (mode != 0) begin
        btn[3] = (m_pl + 25 > m_by + 8);
        btn[2] = (m_pl + 25 < m_by + 2);
      end
      if (mode == 1) begin
        btn[1] = (m_pr + 25 > m_by + 8);
        btn[0] = (m_pr + 25 < m_by + 2);
      end
      tk  = ($urandom_range(0, 3) != 0);
      srv = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 3999) == 0);
      cyc(rs, tk, btn, srv);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
